// File: rtl/fpu_unit_pkg.sv
// Shared definitions for the fpu_unit coprocessor: op-codes, register map,
// FSM states and the binary32 field layout.
package pa_fpu;

    localparam logic [7:0] op_add = 8'h00;
    localparam logic [7:0] op_sub = 8'h01;
    localparam logic [7:0] op_mul = 8'h02;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam logic [5:0] ADDR_A      = 6'h00;
    localparam logic [5:0] ADDR_B      = 6'h04;
    localparam logic [5:0] ADDR_CMD    = 6'h08;
    localparam logic [5:0] ADDR_STATUS = 6'h09;
    localparam logic [5:0] ADDR_RES    = 6'h0C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_EXEC,
        S_NORM,
        S_PACK
    } fpu_state_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float32;

endpackage

// File: rtl/fpu_unit.sv
// Byte-wide memory-mapped binary32 add/sub/mul coprocessor; truncating,
// flush-to-zero, multi-cycle FSM with a sticky completion flag.
module fpu_unit
    import pa_fpu::*;
(
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] databus_in,
    output logic [7:0] databus_out,
    input  logic [5:0] addr,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic       end_ack,
    output logic       cmd_end,
    output logic       busy
);

    logic [31:0] opa, opb, result, special_val;
    logic [7:0]  cmd, exp_x, exp_y, diff;
    fpu_state_t  state;
    logic        wr_prev, wr_act, wr_event;
    logic        res_sign, eff_sub, special;
    logic signed [9:0] res_exp;
    logic [24:0] res_mant, add_sum, mul_sum;
    logic [23:0] man_x, man_y, shifted;
    logic [47:0] prod, prod_next;
    logic [4:0]  step;

    float32 fa, fb;
    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic sb_eff, mul_sign, a_ge_b, sp_hit;
    logic [31:0] sp_val;

    assign wr_act   = ~cs & ~wr;
    assign wr_event = wr_act & ~wr_prev;

    assign fa       = opa;
    assign fb       = opb;
    assign zero_a   = (fa.exp == 8'h00);
    assign zero_b   = (fb.exp == 8'h00);
    assign inf_a    = (fa.exp == 8'hFF) && (fa.mant == 23'd0);
    assign inf_b    = (fb.exp == 8'hFF) && (fb.mant == 23'd0);
    assign nan_a    = (fa.exp == 8'hFF) && (fa.mant != 23'd0);
    assign nan_b    = (fb.exp == 8'hFF) && (fb.mant != 23'd0);
    assign sb_eff   = fb.sign ^ (cmd == op_sub);
    assign mul_sign = fa.sign ^ fb.sign;
    assign a_ge_b   = (opa[30:0] >= opb[30:0]);

    // Operands that bypass the datapath; zero classification covers denormals
    always_comb begin
        sp_hit = 1'b1;
        sp_val = QNAN;
        case (cmd)
            op_add, op_sub: begin
                if (nan_a || nan_b)      sp_val = QNAN;
                else if (inf_a && inf_b) sp_val = (fa.sign == sb_eff) ? {fa.sign, 8'hFF, 23'd0} : QNAN;
                else if (inf_a)          sp_val = {fa.sign, 8'hFF, 23'd0};
                else if (inf_b)          sp_val = {sb_eff, 8'hFF, 23'd0};
                else if (zero_a && zero_b) sp_val = 32'd0;
                else if (zero_a)         sp_val = {sb_eff, opb[30:0]};
                else if (zero_b)         sp_val = {fa.sign, opa[30:0]};
                else                     sp_hit = 1'b0;
            end
            op_mul: begin
                if (nan_a || nan_b)                          sp_val = QNAN;
                else if ((inf_a && zero_b) || (zero_a && inf_b)) sp_val = QNAN;
                else if (inf_a || inf_b)                     sp_val = {mul_sign, 8'hFF, 23'd0};
                else if (zero_a || zero_b)                   sp_val = {mul_sign, 31'd0};
                else                                         sp_hit = 1'b0;
            end
            default: sp_val = QNAN;
        endcase
    end

    assign diff      = exp_x - exp_y;
    assign shifted   = man_y >> diff;
    assign add_sum   = eff_sub ? ({1'b0, man_x} - {1'b0, shifted})
                               : ({1'b0, man_x} + {1'b0, shifted});
    assign mul_sum   = {1'b0, prod[47:24]} + (prod[0] ? {1'b0, man_x} : 25'd0);
    assign prod_next = {mul_sum, prod[23:1]};

    always_ff @(posedge clk) begin
        if (arst) begin
            opa <= '0; opb <= '0; cmd <= '0; result <= '0;
            busy <= 1'b0; cmd_end <= 1'b0; wr_prev <= 1'b0;
            state <= S_IDLE;
            res_sign <= 1'b0; res_exp <= '0; res_mant <= '0;
            man_x <= '0; man_y <= '0; exp_x <= '0; exp_y <= '0;
            eff_sub <= 1'b0; prod <= '0; step <= '0;
            special <= 1'b0; special_val <= '0;
        end else begin
            wr_prev <= wr_act;
            if (end_ack)
                cmd_end <= 1'b0;
            if (wr_event && !busy) begin
                if (addr[5:2] == ADDR_A[5:2])
                    opa[{addr[1:0], 3'b000} +: 8] <= databus_in;
                else if (addr[5:2] == ADDR_B[5:2])
                    opb[{addr[1:0], 3'b000} +: 8] <= databus_in;
                else if (addr == ADDR_CMD) begin
                    cmd     <= databus_in;
                    busy    <= 1'b1;
                    cmd_end <= 1'b0;
                    state   <= S_UNPACK;
                end
            end
            case (state)
                S_UNPACK: begin
                    special     <= sp_hit;
                    special_val <= sp_val;
                    state       <= sp_hit ? S_PACK : S_EXEC;
                    if (cmd == op_mul) begin
                        res_sign <= mul_sign;
                        res_exp  <= $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'sd127;
                        man_x    <= {1'b1, fa.mant};
                        prod     <= {24'd0, 1'b1, fb.mant};
                        step     <= 5'd0;
                    end else if (a_ge_b) begin
                        res_sign <= fa.sign;
                        exp_x <= fa.exp; man_x <= {1'b1, fa.mant};
                        exp_y <= fb.exp; man_y <= {1'b1, fb.mant};
                    end else begin
                        res_sign <= sb_eff;
                        exp_x <= fb.exp; man_x <= {1'b1, fb.mant};
                        exp_y <= fa.exp; man_y <= {1'b1, fa.mant};
                    end
                    eff_sub <= fa.sign ^ sb_eff;
                end
                S_EXEC: begin
                    if (cmd == op_mul) begin
                        prod <= prod_next;
                        step <= step + 5'd1;
                        if (step == 5'd23) begin
                            res_mant <= prod_next[47:23];
                            state    <= S_NORM;
                        end
                    end else if (add_sum == 25'd0) begin
                        special     <= 1'b1;
                        special_val <= 32'd0;
                        state       <= S_PACK;
                    end else begin
                        res_mant <= add_sum;
                        res_exp  <= $signed({2'b00, exp_x});
                        state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (res_mant[24]) begin
                        res_mant <= res_mant >> 1;
                        res_exp  <= res_exp + 10'sd1;
                    end else if (res_mant[23]) begin
                        state <= S_PACK;
                    end else if (res_exp <= 10'sd1) begin
                        special     <= 1'b1;
                        special_val <= {res_sign, 31'd0};
                        state       <= S_PACK;
                    end else begin
                        res_mant <= res_mant << 1;
                        res_exp  <= res_exp - 10'sd1;
                    end
                end
                S_PACK: begin
                    if (special)                  result <= special_val;
                    else if (res_exp >= 10'sd255) result <= {res_sign, 8'hFF, 23'd0};
                    else if (res_exp <= 10'sd0)   result <= {res_sign, 31'd0};
                    else                          result <= {res_sign, res_exp[7:0], res_mant[22:0]};
                    busy    <= 1'b0;
                    cmd_end <= 1'b1;
                    state   <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        databus_out = 8'h00;
        if (!cs && !rd) begin
            if (addr[5:2] == ADDR_A[5:2])        databus_out = opa[{addr[1:0], 3'b000} +: 8];
            else if (addr[5:2] == ADDR_B[5:2])   databus_out = opb[{addr[1:0], 3'b000} +: 8];
            else if (addr[5:2] == ADDR_RES[5:2]) databus_out = result[{addr[1:0], 3'b000} +: 8];
            else if (addr == ADDR_CMD)           databus_out = cmd;
            else if (addr == ADDR_STATUS)        databus_out = {6'b0, cmd_end, busy};
        end
    end

endmodule

// File: tb/tb_fpu_unit.sv
// Scoreboard bench for fpu_unit: expected results are queued at command
// issue and popped when the coprocessor signals completion.
module tb_fpu_unit;
    import pa_fpu::*;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] databus_in, databus_out;
    logic [5:0] addr;
    logic       cs, rd, wr, end_ack, cmd_end, busy;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  op;
        logic [31:0] r;
    } vec_t;

    fpu_unit dut (
        .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(databus_out),
        .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack),
        .cmd_end(cmd_end), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
        @(negedge clk);
        cs = 1'b1; wr = 1'b1;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; cs = 1'b0; rd = 1'b0;
        #1 d = databus_out;
        cs = 1'b1; rd = 1'b1;
    endtask

    task automatic write_word(input logic [5:0] base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bus_write(base + 6'(i), w[8*i +: 8]);
    endtask

    task automatic read_word(input logic [5:0] base, output logic [31:0] w);
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            bus_read(base + 6'(i), d);
            w[8*i +: 8] = d;
        end
    endtask

    task automatic start_op(input logic [7:0] op, input logic [31:0] expected);
        bus_write(ADDR_CMD, op);
        exp_q.push_back(expected);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge clk);
            #1 if (cmd_end) ok = 1'b1;
        end
    endtask

    task automatic ack;
        @(negedge clk); end_ack = 1'b1;
        @(negedge clk); end_ack = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] w;
        logic [7:0]  d;
        arst = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; end_ack = 1'b0;
        databus_in = 8'h00; addr = 6'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); arst = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (cmd_end !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmd_end: got %b expected 0", cmd_end); end
        vectors++; if (databus_out !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_bus: got %h expected 00", databus_out); end
        read_word(ADDR_RES, w);
        vectors++; if (w !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_result: got %h expected 00000000", w); end
        bus_read(ADDR_CMD, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_cmd: got %h expected 00", d); end
    endtask

    task automatic test_denormal_add;
        logic [31:0] w, e;
        bit ok;
        bus_write(6'h00, 8'h55);
        bus_write(6'h01, 8'hAA);
        read_word(ADDR_A, w);
        vectors++; if (w !== 32'h0000AA55) begin miscompares++; $display("[TB] FAIL a_readback: got %h expected 0000aa55", w); end
        start_op(op_add, 32'h0000_0000);
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_rise: got %b expected 1", busy); end
        wait_done(39, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL denorm_latency: got timeout expected cmd_end"); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL denorm_busy_fall: got %b expected 0", busy); end
        read_word(ADDR_RES, w);
        e = exp_q.pop_front();
        vectors++; if (w !== e) begin miscompares++; $display("[TB] FAIL denorm_add: got %h expected %h", w, e); end
        ack();
    endtask

    task automatic test_add_status;
        logic [31:0] w, e;
        logic [7:0]  d;
        bit ok;
        write_word(ADDR_A, 32'h3F80_0000);
        write_word(ADDR_B, 32'h4000_0000);
        start_op(op_add, 32'h4040_0000);
        wait_done(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL add_latency: got timeout expected cmd_end"); end
        read_word(ADDR_RES, w);
        e = exp_q.pop_front();
        vectors++; if (w !== e) begin miscompares++; $display("[TB] FAIL add_1_2: got %h expected %h", w, e); end
        bus_read(ADDR_STATUS, d);
        vectors++; if (d !== 8'h02) begin miscompares++; $display("[TB] FAIL status_done: got %h expected 02", d); end
        ack();
        bus_read(ADDR_STATUS, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL status_acked: got %h expected 00", d); end
    endtask

    task automatic test_arith;
        vec_t tbl [16];
        logic [31:0] w, e;
        bit ok;
        tbl[0]  = {32'h3FC00000, 32'h40000000, op_mul, 32'h40400000};
        tbl[1]  = {32'h3F800000, 32'h3F800000, op_sub, 32'h00000000};
        tbl[2]  = {32'h7F800000, 32'hFF800000, op_add, 32'h7FC00000};
        tbl[3]  = {32'h7F000000, 32'h7F000000, op_mul, 32'h7F800000};
        tbl[4]  = {32'h40000000, 32'h40400000, op_mul, 32'h40C00000};
        tbl[5]  = {32'h40400000, 32'h3F800000, op_sub, 32'h40000000};
        tbl[6]  = {32'h3F800000, 32'h3FC00000, op_sub, 32'hBF000000};
        tbl[7]  = {32'h3F800000, 32'h33800000, op_add, 32'h3F800000};
        tbl[8]  = {32'h00800000, 32'h00800000, op_mul, 32'h00000000};
        tbl[9]  = {32'h80800000, 32'h00800000, op_mul, 32'h80000000};
        tbl[10] = {32'h7F800000, 32'h00000000, op_mul, 32'h7FC00000};
        tbl[11] = {32'h3F800000, 32'h3F800000, 8'h07,  32'h7FC00000};
        tbl[12] = {32'h7F800001, 32'h3F800000, op_add, 32'h7FC00000};
        tbl[13] = {32'h7F800000, 32'hFF800000, op_sub, 32'h7F800000};
        tbl[14] = {32'h7F7FFFFF, 32'h7F7FFFFF, op_add, 32'h7F800000};
        tbl[15] = {32'hC0400000, 32'h40000000, op_mul, 32'hC0C00000};
        for (int i = 0; i < 16; i++) begin
            write_word(ADDR_A, tbl[i].a);
            write_word(ADDR_B, tbl[i].b);
            start_op(tbl[i].op, tbl[i].r);
            wait_done(40, ok);
            vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL arith_latency[%0d]: got timeout expected cmd_end", i); end
            read_word(ADDR_RES, w);
            e = exp_q.pop_front();
            vectors++; if (w !== e) begin miscompares++; $display("[TB] FAIL arith[%0d] %h op%0h %h: got %h expected %h", i, tbl[i].a, tbl[i].op, tbl[i].b, w, e); end
            ack();
        end
    endtask

    task automatic test_busy_write;
        logic [31:0] w, e;
        bit ok;
        write_word(ADDR_A, 32'h3F80_0000);
        write_word(ADDR_B, 32'h4000_0000);
        start_op(op_mul, 32'h4000_0000);
        write_word(ADDR_B, 32'h1234_5678);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_during_mul: got %b expected 1", busy); end
        wait_done(32, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL mul_latency: got timeout expected cmd_end"); end
        read_word(ADDR_RES, w);
        e = exp_q.pop_front();
        vectors++; if (w !== e) begin miscompares++; $display("[TB] FAIL busy_mul_result: got %h expected %h", w, e); end
        read_word(ADDR_B, w);
        vectors++; if (w !== 32'h4000_0000) begin miscompares++; $display("[TB] FAIL busy_b_readback: got %h expected 40000000", w); end
        ack();
    endtask

    task automatic test_strobe_hold;
        logic [31:0] w, e;
        logic [7:0]  d;
        bit ok;
        @(negedge clk); addr = 6'h00; databus_in = 8'h11; cs = 1'b0; wr = 1'b0;
        @(negedge clk); databus_in = 8'h22;
        @(negedge clk); databus_in = 8'h33;
        @(negedge clk); cs = 1'b1; wr = 1'b1;
        bus_read(6'h00, d);
        vectors++; if (d !== 8'h11) begin miscompares++; $display("[TB] FAIL held_strobe_write: got %h expected 11", d); end
        write_word(ADDR_A, 32'h3F80_0000);
        write_word(ADDR_B, 32'h3F80_0000);
        @(negedge clk); addr = ADDR_CMD; databus_in = op_add; cs = 1'b0; wr = 1'b0;
        exp_q.push_back(32'h4000_0000);
        repeat (3) @(negedge clk);
        cs = 1'b1; wr = 1'b1;
        wait_done(38, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL held_cmd_latency: got timeout expected cmd_end"); end
        read_word(ADDR_RES, w);
        e = exp_q.pop_front();
        vectors++; if (w !== e) begin miscompares++; $display("[TB] FAIL held_cmd_result: got %h expected %h", w, e); end
        ack();
        repeat (10) @(posedge clk);
        #1;
        vectors++; if ({busy, cmd_end} !== 2'b00) begin miscompares++; $display("[TB] FAIL held_cmd_single: got %b expected 00", {busy, cmd_end}); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w, e;
        bit ok;
        write_word(ADDR_A, 32'h4040_0000);
        write_word(ADDR_B, 32'h3F80_0000);
        start_op(op_add, 32'h4080_0000);
        wait_done(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL b2b_first_latency: got timeout expected cmd_end"); end
        read_word(ADDR_RES, w);
        e = exp_q.pop_front();
        vectors++; if (w !== e) begin miscompares++; $display("[TB] FAIL b2b_first: got %h expected %h", w, e); end
        start_op(op_sub, 32'h4000_0000);
        vectors++; if ({busy, cmd_end} !== 2'b10) begin miscompares++; $display("[TB] FAIL b2b_cmd_clears_end: got %b expected 10", {busy, cmd_end}); end
        wait_done(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL b2b_second_latency: got timeout expected cmd_end"); end
        read_word(ADDR_RES, w);
        e = exp_q.pop_front();
        vectors++; if (w !== e) begin miscompares++; $display("[TB] FAIL b2b_second: got %h expected %h", w, e); end
        ack();
    endtask

    task automatic test_ack_collision;
        logic [31:0] w, e;
        bit ok;
        write_word(ADDR_A, 32'h4000_0000);
        write_word(ADDR_B, 32'h4000_0000);
        @(negedge clk); end_ack = 1'b1;
        start_op(op_mul, 32'h4080_0000);
        wait_done(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ack_collision_set: got timeout expected cmd_end"); end
        @(posedge clk); #1;
        vectors++; if (cmd_end !== 1'b0) begin miscompares++; $display("[TB] FAIL ack_collision_clear: got %b expected 0", cmd_end); end
        @(negedge clk); end_ack = 1'b0;
        read_word(ADDR_RES, w);
        e = exp_q.pop_front();
        vectors++; if (w !== e) begin miscompares++; $display("[TB] FAIL ack_collision_result: got %h expected %h", w, e); end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] w;
        logic [7:0]  d;
        write_word(ADDR_A, 32'h3FC0_0000);
        write_word(ADDR_B, 32'h4000_0000);
        bus_write(ADDR_CMD, op_mul);
        repeat (5) @(posedge clk);
        @(negedge clk); arst = 1'b1;
        @(posedge clk); #1;
        vectors++; if ({busy, cmd_end} !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_reset_flags: got %b expected 00", {busy, cmd_end}); end
        @(negedge clk); arst = 1'b0;
        read_word(ADDR_RES, w);
        vectors++; if (w !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_result: got %h expected 00000000", w); end
        read_word(ADDR_A, w);
        vectors++; if (w !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_a: got %h expected 00000000", w); end
        bus_read(ADDR_CMD, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_reset_cmd: got %h expected 00", d); end
        repeat (40) @(posedge clk);
        #1;
        vectors++; if ({busy, cmd_end} !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_reset_aborted: got %b expected 00", {busy, cmd_end}); end
    endtask

    initial begin
        test_reset();
        test_denormal_add();
        test_add_status();
        test_arith();
        test_busy_write();
        test_strobe_hold();
        test_back_to_back();
        test_ack_collision();
        test_reset_mid_op();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
